rtc_set_ctrl: RTL
=================

RTC_SET_CTRL -- requirements
Module: rtc_set_ctrl

Interface
REQ-001 Parameter CLKFREQ, default 50000000: clock frequency in Hz.
REQ-002 Parameter TIMEOUT_S, default 10: edit-mode inactivity timeout in seconds.
REQ-003 Parameter BLINK_CYC, default CLKFREQ/4: blink half-period in clock cycles.
REQ-004 clk  in  1  system clock; all logic on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 btn_mode, btn_inc, btn_dec, btn_alarm  in  1 each  debounced, one-cycle button pulses.
REQ-007 cur_hh, cur_mm, cur_ss  in  8 each  live binary time from the RTC (hours 0-23; minutes and seconds 0-59).
REQ-008 wr  out  1  RTC write strobe.
REQ-009 hhmmss  out  32  RTC load value: {8'h00, hh, mm, ss}.
REQ-010 disp_hh, disp_mm, disp_ss  out  8 each  values to display.
REQ-011 edit_field  out  3  one-hot field under edit: [2]=hours, [1]=minutes, [0]=seconds; 0 in RUN.
REQ-012 blink  out  1  field blink phase.
REQ-013 alarm_on, alarm_ring  out  1 each  alarm armed; alarm sounding.

Function
REQ-014 FSM states SHALL be RUN, SET_HH, SET_MM, SET_SS, COMMIT, AL_HH, AL_MM.
REQ-015 btn_mode SHALL advance the FSM: RUN->SET_HH->SET_MM->SET_SS->COMMIT; AL_HH->AL_MM->RUN.
REQ-016 COMMIT SHALL last exactly one cycle and then go unconditionally to AL_HH.
REQ-017 On RUN->SET_HH, edit registers SHALL capture cur_hh/cur_mm/cur_ss in the same edge.
REQ-018 In COMMIT, wr SHALL be 1 for exactly that one cycle and hhmmss SHALL equal {8'h00, edit_hh, edit_mm, edit_ss}; wr SHALL be 0 in every other state.
REQ-019 In SET_* and AL_* states, btn_inc SHALL increment the active field by 1 and btn_dec SHALL decrement it by 1, with wrap-around: hours 23<->0; minutes and seconds 59<->0.
REQ-020 btn_inc and btn_dec in the same cycle SHALL be ignored.
REQ-021 btn_mode together with btn_inc or btn_dec SHALL act as mode only; the field value SHALL be unchanged.
REQ-022 btn_inc, btn_dec and btn_alarm SHALL have no effect on time or alarm values in RUN, except as given in REQ-026 and REQ-028.
REQ-023 Inactivity timeout: in any SET_* or AL_* state, a timeout counter SHALL clear on every button pulse. When the counter reaches TIMEOUT_S*CLKFREQ-1, the FSM SHALL return to RUN next cycle. No wr SHALL be issued, and pending edits SHALL be discarded. Alarm edits already applied SHALL be kept.
REQ-024 disp_* SHALL be cur_* in RUN and COMMIT, edit values in SET_*, and alarm values in AL_*.
REQ-025 blink SHALL toggle every BLINK_CYC cycles in SET_* and AL_* states. It SHALL be forced to 0 and its counter cleared in RUN and COMMIT.
REQ-026 In RUN with alarm_ring=0, btn_alarm SHALL toggle alarm_on.
REQ-027 alarm_ring SHALL set on the cycle following the first cycle in RUN with alarm_on=1, cur_hh==al_hh, cur_mm==al_mm and cur_ss==0.
REQ-028 alarm_ring SHALL clear on btn_alarm (alarm_on unchanged), on cur_mm!=al_mm, on alarm_on=0, or on leaving RUN.
REQ-029 alarm_ring SHALL not re-set within the same matching minute after being cleared by btn_alarm.
REQ-030 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-031 While rst_n=0, all of the following SHALL hold asynchronously: state=RUN, wr=0, hhmmss=0, edit registers=0, al_hh=al_mm=0, alarm_on=0, alarm_ring=0, blink=0, edit_field=0, all counters=0; disp_* SHALL follow cur_*.
REQ-032 Reset asserted mid-edit (including in COMMIT) SHALL abort the edit with no wr pulse.
REQ-033 Operation SHALL resume on the first clk edge after rst_n deasserts.

Verification
REQ-034 cur=12:34:56, then mode, inc x2, mode, dec, mode, mode -> one wr pulse with hhmmss=32'h000E_2138 (14:33:56), then state AL_HH.
REQ-035 In SET_HH at 23: inc -> 0; dec -> 23. In SET_MM at 0: dec -> 59.
REQ-036 Enter SET_HH, then no buttons for TIMEOUT_S*CLKFREQ cycles (CLKFREQ overridden to 100) -> back in RUN, wr never asserted, disp follows cur.
REQ-037 al=07:30, alarm_on=1; drive cur 07:29:59 -> 07:30:00 -> alarm_ring=1 one cycle later; btn_alarm -> ring=0 and stays 0 through 07:30:59.
REQ-038 inc+dec in the same cycle, and mode+inc in the same cycle -> field value unchanged in both cases; state advances only for mode+inc.
REQ-039 Drop rst_n in COMMIT's cycle -> wr=0 immediately, state=RUN, alarm_on=0.

Source files
------------

// File: rtl/rtc_set_ctrl.sv
// rtc_set_ctrl: button-driven time/alarm setting controller for an RTC.
// Edits the current time field by field, commits it with a one-cycle write
// strobe, then lets the user adjust the alarm hour and minute. All outputs
// are registered; display values select live time, edit copy or alarm.
module rtc_set_ctrl #(
    parameter int CLKFREQ   = 50000000,
    parameter int TIMEOUT_S = 10,
    parameter int BLINK_CYC = CLKFREQ / 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic        btn_alarm,
    input  logic [7:0]  cur_hh,
    input  logic [7:0]  cur_mm,
    input  logic [7:0]  cur_ss,
    output logic        wr,
    output logic [31:0] hhmmss,
    output logic [7:0]  disp_hh,
    output logic [7:0]  disp_mm,
    output logic [7:0]  disp_ss,
    output logic [2:0]  edit_field,
    output logic        blink,
    output logic        alarm_on,
    output logic        alarm_ring
);

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        SET_HH = 3'd1,
        SET_MM = 3'd2,
        SET_SS = 3'd3,
        COMMIT = 3'd4,
        AL_HH  = 3'd5,
        AL_MM  = 3'd6
    } state_t;

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_S * CLKFREQ - 1);
    localparam logic [31:0] BL_LAST = 32'(BLINK_CYC - 1);

    // Step a field by one with wrap-around between 0 and top.
    function automatic logic [7:0] step_wrap(input logic [7:0] v, input logic [7:0] top,
                                             input logic up);
        logic [7:0] r;
        if (up) begin
            if (v >= top) r = 8'd0;
            else          r = v + 8'd1;
        end else begin
            if ((v == 8'd0) || (v > top)) r = top;
            else                          r = v - 8'd1;
        end
        return r;
    endfunction

    // True for the states where the user is adjusting a field.
    function automatic logic is_edit(input state_t s);
        logic r;
        case (s)
            SET_HH, SET_MM, SET_SS, AL_HH, AL_MM: r = 1'b1;
            default:                              r = 1'b0;
        endcase
        return r;
    endfunction

    state_t      state_r, state_nxt_s;
    logic [7:0]  edit_hh_r, edit_mm_r, edit_ss_r;
    logic [7:0]  edit_hh_nxt_s, edit_mm_nxt_s, edit_ss_nxt_s;
    logic [7:0]  al_hh_r, al_mm_r, al_hh_nxt_s, al_mm_nxt_s;
    logic [31:0] tcnt_r, bcnt_r, hhmmss_r;
    logic        wr_r, blink_r, alarm_on_r, alarm_ring_r, al_done_r;
    logic [2:0]  edit_field_r;
    logic [7:0]  disp_hh_r, disp_mm_r, disp_ss_r;
    logic        any_btn_s, adj_s, timeout_s, match_min_s, ring_set_s, ring_clr_s;

    // Mode wins over inc/dec; simultaneous inc and dec cancel out.
    assign any_btn_s   = btn_mode | btn_inc | btn_dec | btn_alarm;
    assign adj_s       = (btn_inc ^ btn_dec) & ~btn_mode;
    assign timeout_s   = is_edit(state_r) & ~any_btn_s & (tcnt_r == TO_LAST);
    assign match_min_s = (cur_hh == al_hh_r) && (cur_mm == al_mm_r);
    assign ring_set_s  = (state_r == RUN) && alarm_on_r && match_min_s && (cur_ss == 8'd0)
                         && !al_done_r && !alarm_ring_r;
    assign ring_clr_s  = btn_alarm || (cur_mm != al_mm_r) || !alarm_on_r || (state_nxt_s != RUN);

    // Next-state and next field values for the edit/alarm registers.
    always_comb begin
        state_nxt_s   = state_r;
        edit_hh_nxt_s = edit_hh_r;
        edit_mm_nxt_s = edit_mm_r;
        edit_ss_nxt_s = edit_ss_r;
        al_hh_nxt_s   = al_hh_r;
        al_mm_nxt_s   = al_mm_r;
        if (timeout_s) begin
            state_nxt_s = RUN;
        end else begin
            case (state_r)
                RUN: begin
                    if (btn_mode) begin
                        state_nxt_s   = SET_HH;
                        edit_hh_nxt_s = cur_hh;
                        edit_mm_nxt_s = cur_mm;
                        edit_ss_nxt_s = cur_ss;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                SET_HH: begin
                    if (btn_mode)   state_nxt_s = SET_MM;
                    else if (adj_s) edit_hh_nxt_s = step_wrap(edit_hh_r, 8'd23, btn_inc);
                    else            state_nxt_s = SET_HH;
                end
                SET_MM: begin
                    if (btn_mode)   state_nxt_s = SET_SS;
                    else if (adj_s) edit_mm_nxt_s = step_wrap(edit_mm_r, 8'd59, btn_inc);
                    else            state_nxt_s = SET_MM;
                end
                SET_SS: begin
                    if (btn_mode)   state_nxt_s = COMMIT;
                    else if (adj_s) edit_ss_nxt_s = step_wrap(edit_ss_r, 8'd59, btn_inc);
                    else            state_nxt_s = SET_SS;
                end
                COMMIT: state_nxt_s = AL_HH;
                AL_HH: begin
                    if (btn_mode)   state_nxt_s = AL_MM;
                    else if (adj_s) al_hh_nxt_s = step_wrap(al_hh_r, 8'd23, btn_inc);
                    else            state_nxt_s = AL_HH;
                end
                AL_MM: begin
                    if (btn_mode)   state_nxt_s = RUN;
                    else if (adj_s) al_mm_nxt_s = step_wrap(al_mm_r, 8'd59, btn_inc);
                    else            state_nxt_s = AL_MM;
                end
                default: state_nxt_s = RUN;
            endcase
        end
    end

    // State, edit/alarm values, write strobe and field indicator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= RUN;
            edit_hh_r    <= 8'd0;
            edit_mm_r    <= 8'd0;
            edit_ss_r    <= 8'd0;
            al_hh_r      <= 8'd0;
            al_mm_r      <= 8'd0;
            wr_r         <= 1'b0;
            hhmmss_r     <= 32'd0;
            edit_field_r <= 3'b000;
        end else begin
            state_r   <= state_nxt_s;
            edit_hh_r <= edit_hh_nxt_s;
            edit_mm_r <= edit_mm_nxt_s;
            edit_ss_r <= edit_ss_nxt_s;
            al_hh_r   <= al_hh_nxt_s;
            al_mm_r   <= al_mm_nxt_s;
            wr_r      <= (state_nxt_s == COMMIT);
            if (state_nxt_s == COMMIT) hhmmss_r <= {8'h00, edit_hh_nxt_s, edit_mm_nxt_s, edit_ss_nxt_s};
            else                       hhmmss_r <= hhmmss_r;
            case (state_nxt_s)
                SET_HH, AL_HH: edit_field_r <= 3'b100;
                SET_MM, AL_MM: edit_field_r <= 3'b010;
                SET_SS:        edit_field_r <= 3'b001;
                default:       edit_field_r <= 3'b000;
            endcase
        end
    end

    // Inactivity counter: runs only while editing, cleared by any button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              tcnt_r <= 32'd0;
        else if (!is_edit(state_r) || any_btn_s) tcnt_r <= 32'd0;
        else                                     tcnt_r <= tcnt_r + 32'd1;
    end

    // Blink phase generator, restarted on entry to the edit states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_r  <= 32'd0;
            blink_r <= 1'b0;
        end else if (!is_edit(state_r) || !is_edit(state_nxt_s)) begin
            bcnt_r  <= 32'd0;
            blink_r <= 1'b0;
        end else if (bcnt_r == BL_LAST) begin
            bcnt_r  <= 32'd0;
            blink_r <= ~blink_r;
        end else begin
            bcnt_r  <= bcnt_r + 32'd1;
            blink_r <= blink_r;
        end
    end

    // Alarm arming, ringing and once-per-minute latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_on_r   <= 1'b0;
            alarm_ring_r <= 1'b0;
            al_done_r    <= 1'b0;
        end else begin
            if ((state_r == RUN) && btn_alarm && !alarm_ring_r) alarm_on_r <= ~alarm_on_r;
            else                                               alarm_on_r <= alarm_on_r;
            if (ring_clr_s)      alarm_ring_r <= 1'b0;
            else if (ring_set_s) alarm_ring_r <= 1'b1;
            else                 alarm_ring_r <= alarm_ring_r;
            if (!match_min_s)    al_done_r <= 1'b0;
            else if (ring_set_s) al_done_r <= 1'b1;
            else                 al_done_r <= al_done_r;
        end
    end

    // Display registers; with no buttons they track the live time, also in reset.
    always_ff @(posedge clk) begin
        case (state_nxt_s)
            SET_HH, SET_MM, SET_SS: begin
                disp_hh_r <= edit_hh_nxt_s;
                disp_mm_r <= edit_mm_nxt_s;
                disp_ss_r <= edit_ss_nxt_s;
            end
            AL_HH, AL_MM: begin
                disp_hh_r <= al_hh_nxt_s;
                disp_mm_r <= al_mm_nxt_s;
                disp_ss_r <= 8'd0;
            end
            default: begin
                disp_hh_r <= cur_hh;
                disp_mm_r <= cur_mm;
                disp_ss_r <= cur_ss;
            end
        endcase
    end

    assign wr         = wr_r;
    assign hhmmss     = hhmmss_r;
    assign disp_hh    = disp_hh_r;
    assign disp_mm    = disp_mm_r;
    assign disp_ss    = disp_ss_r;
    assign edit_field = edit_field_r;
    assign blink      = blink_r;
    assign alarm_on   = alarm_on_r;
    assign alarm_ring = alarm_ring_r;

endmodule
